// File: rtl/key_decode_if.sv
// key_decode_if: keypad scan bundle between the scanner/pins and the key decoder.
interface key_decode_if;
    logic [3:0] row;
    logic [3:0] key_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_release;
    logic       key_down;
    modport master (output row, key_col, input key_code, key_valid, key_release, key_down);
    modport slave  (input row, key_col, output key_code, key_valid, key_release, key_down);
endinterface

// File: rtl/key_decode.sv
// key_decode: debounced 4x4 keypad decoder; aligns scanner rows with synchronized columns
// and emits a key code with press/release strobes and a held level.
module key_decode #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int CNT_W           = 32
) (
    input logic         clk,
    input logic         rst_n,
    key_decode_if.slave kp
);
    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_e;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    state_e           state_q;
    logic [3:0]       col_s1_q, col_s2_q, row_d1_q, row_d2_q, cap_row_q, code_q;
    logic [1:0]       cap_col_q;
    logic [CNT_W-1:0] cnt_q;
    logic             valid_q, release_q, down_q;
    logic             sample_ok, row_hit, col_hit, col_match, cnt_done;
    function automatic logic [1:0] idx(input logic [3:0] v);
        return v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
    endfunction
    function automatic logic onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction
    // Rows ride a matching two-stage delay so each row lines up with the columns it produced.
    assign sample_ok = onehot(row_d2_q) && onehot(col_s2_q);
    assign row_hit   = row_d2_q == cap_row_q;
    assign col_hit   = col_s2_q[cap_col_q];
    assign col_match = col_s2_q == (4'd1 << cap_col_q);
    assign cnt_done  = cnt_q == CNT_MAX;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_s1_q  <= '0;
            col_s2_q  <= '0;
            row_d1_q  <= '0;
            row_d2_q  <= '0;
            cap_row_q <= '0;
            cap_col_q <= '0;
            cnt_q     <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            release_q <= 1'b0;
            down_q    <= 1'b0;
            state_q   <= IDLE;
        end else begin
            col_s1_q  <= kp.key_col;
            col_s2_q  <= col_s1_q;
            row_d1_q  <= kp.row;
            row_d2_q  <= row_d1_q;
            valid_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                IDLE: if (sample_ok) begin
                    cap_row_q <= row_d2_q;
                    cap_col_q <= idx(col_s2_q);
                    cnt_q     <= '0;
                    state_q   <= PRESS_DB;
                end
                PRESS_DB: if (row_hit) begin
                    if (!col_match) state_q <= IDLE;
                    else if (cnt_done) begin
                        code_q  <= {idx(cap_row_q), cap_col_q};
                        valid_q <= 1'b1;
                        down_q  <= 1'b1;
                        state_q <= HELD;
                    end else cnt_q <= cnt_q + CNT_W'(1);
                end
                HELD: if (row_hit && !col_hit) begin
                    cnt_q   <= '0;
                    state_q <= RELEASE_DB;
                end
                RELEASE_DB: if (row_hit) begin
                    if (col_hit) state_q <= HELD;
                    else if (cnt_done) begin
                        release_q <= 1'b1;
                        down_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else cnt_q <= cnt_q + CNT_W'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign kp.key_code    = code_q;
    assign kp.key_valid   = valid_q;
    assign kp.key_release = release_q;
    assign kp.key_down    = down_q;
endmodule

// File: tb/tb_key_decode.sv
// tb_key_decode: directed keypad scenarios; expected strobes are queued at stimulus time
// and a negedge monitor pops and compares them against every strobe the decoder emits.
module tb_key_decode;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    key_decode_if kif();
    key_decode #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .kp(kif));
    typedef struct {bit rel; logic [3:0] code; int cyc;} want_t;
    want_t q[$];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input int act, input int want);
        n_chk++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask
    // Every strobe must match the oldest queued expectation, including its cycle.
    always @(negedge clk) begin
        if (kif.key_valid || kif.key_release) begin
            chk("strobe_exclusive", int'(kif.key_valid && kif.key_release), 0);
            if (q.size() == 0) chk("unexpected_strobe", int'({kif.key_valid, kif.key_release}), 0);
            else begin
                want_t w;
                w = q.pop_front();
                chk("strobe_kind", int'(kif.key_release), int'(w.rel));
                chk("strobe_code", int'(kif.key_code), int'(w.code));
                chk("strobe_down", int'(kif.key_down), int'(!w.rel));
                chk("strobe_cycle", cyc, w.cyc);
            end
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic [3:0] r, input logic [3:0] c);
        kif.row = r;
        kif.key_col = c;
    endtask
    task automatic expect_evt(input bit rel, input logic [3:0] code, input int at);
        q.push_back('{rel, code, at});
    endtask
    task automatic drain(input string name);
        for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            chk({name, "_timeout"}, q.size(), 0);
            q.delete();
        end
        #1;
    endtask
    task automatic chk_outs(input string name, input int code, input int down);
        chk({name, "_code"}, int'(kif.key_code), code);
        chk({name, "_down"}, int'(kif.key_down), down);
    endtask
    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end
    initial begin
        drive(4'h0, 4'h0);
        repeat (3) step();
        chk_outs("reset", 0, 0);
        chk("reset_valid", int'(kif.key_valid), 0);
        chk("reset_release", int'(kif.key_release), 0);
        rst_n = 1'b1;
        step();
        // Stable key 6: press accepted 7 cycles after the pins settle.
        drive(4'h2, 4'h4);
        expect_evt(1'b0, 4'd6, cyc + 7);
        drain("press6");
        chk_outs("held6", 6, 1);
        // Two-cycle dip is a bounce; a long drop is a release.
        drive(4'h2, 4'h0);
        repeat (2) step();
        drive(4'h2, 4'h4);
        repeat (8) step();
        chk_outs("bounce6", 6, 1);
        drive(4'h2, 4'h0);
        expect_evt(1'b1, 4'd6, cyc + 7);
        drain("release6");
        repeat (3) step();
        chk_outs("released6", 6, 0);
        // Rotating rows: count only advances during the row-8 dwell.
        begin
            int s;
            s = cyc;
            expect_evt(1'b0, 4'd13, s + 25);
            expect_evt(1'b1, 4'd13, s + 49);
            for (int k = 0; k < 48; k++) begin
                logic [3:0] r;
                r = 4'h1 << ((k / 3) % 4);
                drive(r, (r == 4'h8 && k < 24) ? 4'h2 : 4'h0);
                step();
            end
            drain("rotate13");
        end
        drive(4'h0, 4'h0);
        repeat (5) step();
        chk_outs("rotated13", 13, 0);
        // Two columns at once is ghosting and must not start a press.
        drive(4'h1, 4'h5);
        repeat (20) step();
        chk_outs("ghost", 13, 0);
        drive(4'h1, 4'h1);
        expect_evt(1'b0, 4'd0, cyc + 7);
        drain("press0");
        drive(4'h1, 4'h0);
        expect_evt(1'b1, 4'd0, cyc + 7);
        drain("release0");
        repeat (3) step();
        // Other keys while key 6 is held are ignored.
        drive(4'h2, 4'h4);
        expect_evt(1'b0, 4'd6, cyc + 7);
        drain("press6b");
        drive(4'h8, 4'h1);
        repeat (12) step();
        drive(4'h2, 4'hC);
        repeat (10) step();
        chk_outs("rollover", 6, 1);
        drive(4'h2, 4'h0);
        expect_evt(1'b1, 4'd6, cyc + 7);
        drain("release6b");
        repeat (3) step();
        // Reset while held: outputs clear without a release, then the key re-debounces.
        drive(4'h2, 4'h4);
        expect_evt(1'b0, 4'd6, cyc + 7);
        drain("press6c");
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_outs("midreset", 0, 0);
        chk("midreset_valid", int'(kif.key_valid), 0);
        chk("midreset_release", int'(kif.key_release), 0);
        expect_evt(1'b0, 4'd6, cyc + 7);
        drain("repress6");
        chk_outs("repressed6", 6, 1);
        drive(4'h2, 4'h0);
        expect_evt(1'b1, 4'd6, cyc + 7);
        drain("release6c");
        repeat (3) step();
        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
